// File: rtl/sram_test_pkg.sv
// -----------------------------------------------------------------------------
// sram_test_pkg
// Shared definitions for the SRAM write-then-verify sequencer:
//   - sequencer state codes (IDLE .. FINISH)
//   - data pattern selector codes
//   - pattern_word(): the data pattern as a function of address and selector
// -----------------------------------------------------------------------------
package sram_test_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WR     = 3'd1;
  localparam logic [2:0] ST_WR_GAP = 3'd2;
  localparam logic [2:0] ST_RD     = 3'd3;
  localparam logic [2:0] ST_RD_GAP = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;

  localparam logic [1:0] PAT_ADDR    = 2'd0;
  localparam logic [1:0] PAT_NADDR   = 2'd1;
  localparam logic [1:0] PAT_CHECKER = 2'd2;
  localparam logic [1:0] PAT_ZERO    = 2'd3;

  // Produces a 32-bit word; callers keep the low DATA_W bits. The checker
  // constants are replicated so any data width up to 32 sees an AA/55 pair.
  function automatic logic [31:0] pattern_word(input logic [31:0] a,
                                               input logic [1:0]  sel);
    case (sel)
      PAT_ADDR:    return a;
      PAT_NADDR:   return ~a;
      PAT_CHECKER: return a[0] ? 32'hAAAA_AAAA : 32'h5555_5555;
      default:     return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/sram_test_sequencer_if.sv
// -----------------------------------------------------------------------------
// sram_test_sequencer_if
// Request/acknowledge bus between the test sequencer and the SRAM controller.
//   mem_req   : access request (master -> slave)
//   mem_we    : 1 = write, 0 = read, valid while mem_req
//   mem_addr  : access address
//   mem_wdata : write data
//   mem_ack   : one-cycle completion (slave -> master)
//   mem_rdata : read data, valid in the mem_ack cycle of a read
// -----------------------------------------------------------------------------
interface sram_test_sequencer_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/sram_pattern_gen.sv
// -----------------------------------------------------------------------------
// sram_pattern_gen
// Combinational data pattern for a given address and latched selector. One
// instance feeds both the write data and the expected read data, so writes
// and compares can never disagree about the pattern.
//   addr : current test address
//   sel  : latched pattern selector
//   data : pattern value for addr
// -----------------------------------------------------------------------------
module sram_pattern_gen
  import sram_test_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        sel,
  output logic [DATA_W-1:0] data
);

  logic [31:0] word;
  logic        unused_hi;

  assign word      = pattern_word(32'(addr), sel);
  assign data      = word[DATA_W-1:0];
  assign unused_hi = ^word[31:DATA_W];

endmodule

// File: rtl/sram_test_sequencer.sv
// -----------------------------------------------------------------------------
// sram_test_sequencer
// Runs one write-then-verify pass over SRAM addresses [0, LAST_ADDR] per
// accepted start event: writes the selected pattern everywhere, reads every
// location back and compares it, then reports the result.
//   clk, rst_n    : clock, asynchronous active-low reset
//   start_pulse   : one-cycle start event (ignored while busy)
//   abort_pulse   : one-cycle abort event (wins over start in IDLE)
//   pattern_sel   : pattern choice, latched on an accepted start
//   mem           : master side of the SRAM request/ack bus
//   busy          : pass in progress
//   done          : one-cycle pulse on normal completion
//   pass          : last completed pass had no mismatches
//   err_count     : saturating mismatch count of current/last pass
//   fail_addr     : address of first mismatch, 0 if none
// -----------------------------------------------------------------------------
module sram_test_sequencer
  import sram_test_pkg::*;
#(
  parameter int                ADDR_W    = 19,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}},
  parameter int                ERR_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_pulse,
  input  logic                 abort_pulse,
  input  logic [1:0]           pattern_sel,
  sram_test_sequencer_if.master mem,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [ADDR_W-1:0]    fail_addr
);

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        pat_sel;
  logic [DATA_W-1:0] pat_data;
  logic              at_last;
  logic              rd_mismatch;

  sram_pattern_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pattern (
    .addr (addr),
    .sel  (pat_sel),
    .data (pat_data)
  );

  assign at_last     = (addr == LAST_ADDR);
  assign rd_mismatch = (mem.mem_rdata != pat_data);

  // Bus outputs decode straight from the state register, so the asynchronous
  // reset drops mem_req without waiting for a clock edge.
  assign mem.mem_req   = (state == ST_WR) || (state == ST_RD);
  assign mem.mem_we    = (state == ST_WR);
  assign mem.mem_addr  = addr;
  assign mem.mem_wdata = (state == ST_WR) ? pat_data : '0;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_FINISH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addr      <= '0;
      pat_sel   <= PAT_ADDR;
      err_count <= '0;
      fail_addr <= '0;
      pass      <= 1'b0;
    end else if ((state != ST_IDLE) && abort_pulse) begin
      // An ack in the abort cycle is deliberately dropped; partial error
      // results are kept for inspection.
      state <= ST_IDLE;
      pass  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_pulse && !abort_pulse) begin
            pat_sel   <= pattern_sel;
            err_count <= '0;
            fail_addr <= '0;
            pass      <= 1'b0;
            addr      <= '0;
            state     <= ST_WR;
          end
        end
        ST_WR: begin
          if (mem.mem_ack) state <= ST_WR_GAP;
        end
        ST_WR_GAP: begin
          if (at_last) begin
            addr  <= '0;
            state <= ST_RD;
          end else begin
            addr  <= addr + 1'b1;
            state <= ST_WR;
          end
        end
        ST_RD: begin
          if (mem.mem_ack) begin
            if (rd_mismatch) begin
              // err_count only leaves zero on the first mismatch and never
              // wraps back, so zero doubles as "no mismatch seen yet".
              if (err_count == '0) fail_addr <= addr;
              if (err_count != '1) err_count <= err_count + 1'b1;
            end
            state <= ST_RD_GAP;
          end
        end
        ST_RD_GAP: begin
          if (at_last) begin
            // The last compare has already landed in err_count here, so
            // pass becomes valid in the same cycle as done.
            pass  <= (err_count == '0);
            state <= ST_FINISH;
          end else begin
            addr  <= addr + 1'b1;
            state <= ST_RD;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_test_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sram_test_sequencer
// Directed + randomized bench for sram_test_sequencer with a 16-location SRAM
// model that acks in the second cycle of each request and can corrupt reads.
// -----------------------------------------------------------------------------
module tb_sram_test_sequencer;

  localparam int                ADDR_W = 4;
  localparam int                DATA_W = 8;
  localparam int                ERR_W  = 3;
  localparam int                LAST   = 15;
  localparam logic [ADDR_W-1:0] LAST_A = 4'd15;
  localparam int                ACK_L  = 2;
  localparam int                N_ACC  = 2 * (LAST + 1);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  logic              clk;
  logic              rst_n;
  logic              start_pulse;
  logic              abort_pulse;
  logic [1:0]        pattern_sel;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_count;
  logic [ADDR_W-1:0] fail_addr;

  logic              model_ack;
  logic [DATA_W-1:0] model_rdata;
  logic              stray_ack;
  logic [15:0]       corrupt_mask;
  logic              corrupt_all;
  logic [DATA_W-1:0] store [16];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_done = 0;
  int   gap_viol = 0;
  logic prev_acc = 1'b0;
  txn_t txq [$];

  sram_test_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  sram_test_sequencer #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .LAST_ADDR (LAST_A),
    .ERR_W     (ERR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_pulse (start_pulse),
    .abort_pulse (abort_pulse),
    .pattern_sel (pattern_sel),
    .mem         (mem_bus),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_count   (err_count),
    .fail_addr   (fail_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_bus.mem_ack   = model_ack | stray_ack;
  assign mem_bus.mem_rdata = model_rdata;

  // SRAM model: ack in the second request cycle, read data optionally
  // corrupted (bit 0 per masked address, or all bits when corrupt_all).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_ack   <= 1'b0;
      model_rdata <= '0;
    end else if (model_ack) begin
      model_ack   <= 1'b0;
      model_rdata <= '0;
    end else if (mem_bus.mem_req) begin
      model_ack   <= 1'b1;
      model_rdata <= store[mem_bus.mem_addr] ^
                     (corrupt_all ? 8'hFF : {7'b0, corrupt_mask[mem_bus.mem_addr]});
    end
  end

  always @(posedge clk) begin
    if (mem_bus.mem_req && mem_bus.mem_we && mem_bus.mem_ack)
      store[mem_bus.mem_addr] <= mem_bus.mem_wdata;
  end

  // Bus monitor: records completed accesses, counts done pulses and any
  // cycle where mem_req stays high right after an acknowledged access.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_acc <= 1'b0;
    end else begin
      if (prev_acc && mem_bus.mem_req) gap_viol <= gap_viol + 1;
      prev_acc <= mem_bus.mem_req && mem_bus.mem_ack;
      if (mem_bus.mem_req && mem_bus.mem_ack)
        txq.push_back({mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata});
      if (done) n_done <= n_done + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_pat(input int a, input logic [1:0] sel);
    case (sel)
      2'd0:    return 8'(a % 256);
      2'd1:    return 8'(255 - (a % 256));
      2'd2:    return ((a % 2) == 1) ? 8'hAA : 8'h55;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] corruption(input int a);
    return corrupt_all ? 8'hFF : {7'b0, corrupt_mask[a]};
  endfunction

  // Expected access stream: writes 0..LAST with the pattern, then reads
  // 0..LAST with zero write data; n_acc truncates it for aborted passes.
  task automatic verify_txns(input string name, input int base, input logic [1:0] sel, input int n_acc);
    logic       w;
    int         a;
    logic [3:0] a4;
    logic [7:0] d;
    check({name, "_txn_count"}, txq.size() - base, n_acc);
    for (int i = 0; i < n_acc && (base + i) < txq.size(); i++) begin
      w  = (i <= LAST);
      a  = w ? i : i - (LAST + 1);
      a4 = a[3:0];
      d  = w ? ref_pat(a, sel) : 8'h00;
      check($sformatf("%s_txn%0d", name, i), 32'(txq[base + i]), 32'({w, a4, d}));
    end
  endtask

  task automatic run_pass(input logic [1:0] sel, input int mid_start_at, output int lat, output bit seen);
    int s;
    @(negedge clk);
    pattern_sel = sel;
    start_pulse = 1'b1;
    s = cyc;
    @(negedge clk);
    start_pulse = 1'b0;
    check("busy_after_start", busy, 1);
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (done) begin
        seen = 1'b1;
        lat  = cyc - s + 1;
      end else begin
        if (i == mid_start_at) begin
          start_pulse = 1'b1;
          pattern_sel = ~sel;
        end
        @(negedge clk);
        start_pulse = 1'b0;
      end
    end
  endtask

  task automatic full_pass(input string name, input logic [1:0] sel, input int mid_start_at);
    int   base, db, gb, lat, cnt, fa;
    bit   seen, found;
    logic [7:0] obs;
    base  = txq.size();
    db    = n_done;
    gb    = gap_viol;
    cnt   = 0;
    fa    = 0;
    found = 1'b0;
    for (int a = 0; a <= LAST; a++) begin
      obs = ref_pat(a, sel) ^ corruption(a);
      if (obs != ref_pat(a, sel)) begin
        cnt++;
        if (!found) begin
          fa    = a;
          found = 1'b1;
        end
      end
    end
    run_pass(sel, mid_start_at, lat, seen);
    check({name, "_done_seen"}, seen, 1);
    check({name, "_latency"}, lat, 2 * (ACK_L + 1) * (LAST + 1) + 2);
    check({name, "_pass"}, pass, (cnt == 0));
    check({name, "_err_count"}, err_count, (cnt > 7) ? 7 : cnt);
    check({name, "_fail_addr"}, fail_addr, fa);
    @(negedge clk);
    check({name, "_done_one_cycle"}, done, 0);
    check({name, "_busy_after_finish"}, busy, 0);
    repeat (3) @(negedge clk);
    check({name, "_pass_held"}, pass, (cnt == 0));
    check({name, "_done_pulses"}, n_done - db, 1);
    check({name, "_req_gap"}, gap_viol - gb, 0);
    verify_txns(name, base, sel, N_ACC);
  endtask

  task automatic abort_test();
    int         base, db;
    bit         hit;
    logic [1:0] sel;
    sel          = 2'($urandom_range(0, 3));
    corrupt_mask = 16'h0084;
    corrupt_all  = 1'b0;
    base         = txq.size();
    db           = n_done;
    hit          = 1'b0;
    @(negedge clk);
    pattern_sel = sel;
    start_pulse = 1'b1;
    @(negedge clk);
    start_pulse = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      if (mem_bus.mem_req && !mem_bus.mem_we && mem_bus.mem_addr == 4'd7 && mem_bus.mem_ack)
        hit = 1'b1;
      else
        @(negedge clk);
    end
    check("abort_read7_ack_seen", hit, 1);
    abort_pulse = 1'b1;
    @(negedge clk);
    abort_pulse = 1'b0;
    check("abort_req_low", mem_bus.mem_req, 0);
    check("abort_busy", busy, 0);
    check("abort_pass", pass, 0);
    check("abort_err_partial", err_count, 1);
    check("abort_fail_addr", fail_addr, 2);
    repeat (10) @(negedge clk);
    check("abort_req_stays_low", mem_bus.mem_req, 0);
    check("abort_err_kept", err_count, 1);
    check("abort_no_done", n_done - db, 0);
    verify_txns("abort", base, sel, (LAST + 1) + 8);
    corrupt_mask = '0;
  endtask

  task automatic idle_conflict_test();
    int db;
    db = n_done;
    @(negedge clk);
    start_pulse = 1'b1;
    abort_pulse = 1'b1;
    @(negedge clk);
    start_pulse = 1'b0;
    abort_pulse = 1'b0;
    check("conflict_busy", busy, 0);
    check("conflict_req", mem_bus.mem_req, 0);
    repeat (5) @(negedge clk);
    check("conflict_req_later", mem_bus.mem_req, 0);
    check("conflict_no_done", n_done - db, 0);
  endtask

  task automatic reset_test();
    bit         hit;
    logic [1:0] sel1, sel2;
    sel1 = 2'($urandom_range(0, 3));
    sel2 = sel1 + 2'd1;
    hit  = 1'b0;
    @(negedge clk);
    pattern_sel = sel1;
    start_pulse = 1'b1;
    @(negedge clk);
    start_pulse = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (mem_bus.mem_req && mem_bus.mem_we && mem_bus.mem_addr == 4'd3)
        hit = 1'b1;
      else
        @(negedge clk);
    end
    check("rst_wr3_seen", hit, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_req", mem_bus.mem_req, 0);
    check("rst_async_we", mem_bus.mem_we, 0);
    check("rst_async_addr", mem_bus.mem_addr, 0);
    check("rst_async_wdata", mem_bus.mem_wdata, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    full_pass("after_reset", sel2, -1);
  endtask

  initial begin
    rst_n        = 1'b0;
    start_pulse  = 1'b0;
    abort_pulse  = 1'b0;
    pattern_sel  = 2'd0;
    stray_ack    = 1'b0;
    corrupt_mask = '0;
    corrupt_all  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_req", mem_bus.mem_req, 0);
    check("reset_we", mem_bus.mem_we, 0);
    check("reset_addr", mem_bus.mem_addr, 0);
    check("reset_wdata", mem_bus.mem_wdata, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_pass", pass, 0);
    check("reset_err", err_count, 0);
    check("reset_fail_addr", fail_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_busy", busy, 0);
    check("stray_ack_req", mem_bus.mem_req, 0);
    check("stray_ack_err", err_count, 0);

    full_pass("addr_pattern", 2'd0, -1);

    corrupt_mask = 16'h0220;
    full_pass("checker_flip", 2'd2, -1);

    corrupt_mask = '0;
    corrupt_all  = 1'b1;
    full_pass("saturate", 2'($urandom_range(0, 3)), -1);
    corrupt_all  = 1'b0;

    for (int k = 0; k < 4; k++) begin
      corrupt_mask = 16'($urandom) & 16'($urandom);
      full_pass($sformatf("random%0d", k), 2'($urandom_range(0, 3)), -1);
    end

    corrupt_mask = '0;
    full_pass("mid_start", 2'($urandom_range(0, 3)), 10);

    abort_test();
    idle_conflict_test();
    reset_test();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
